// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D-cache memory arbiter.
//   BLOCK_WORDS : words per cache block (power of 2)
//   WORD_IDX_W  : width of a word index within a block
//   state_e     : arbiter FSM states
//   grant_e     : grant owner encoding
package mem_arb_pkg;

  localparam int unsigned BLOCK_WORDS = 8;
  localparam int unsigned WORD_IDX_W  = $clog2(BLOCK_WORDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_FILL  = 2'd1,
    D_FILL  = 2'd2,
    D_WRITE = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache miss handlers, the arbiter and main memory.
//   I side : i_req, i_addr -> i_fill_valid, i_done
//   D side : d_req, d_wr, d_addr, d_wdata -> d_fill_valid, d_done
//   shared : fill_data, fill_word, busy
//   memory : mem_en, mem_wr, mem_addr, mem_wdata -> mem_rdata, mem_rvalid
// slave modport is the arbiter's view; master is the caches/memory view.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) ();

  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_fill_valid;
  logic                  i_done;

  logic                  d_req;
  logic                  d_wr;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_fill_valid;
  logic                  d_done;

  logic [DATA_W-1:0]     fill_data;
  logic [WORD_IDX_W-1:0] fill_word;
  logic                  busy;

  logic                  mem_en;
  logic                  mem_wr;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_rvalid;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
    output i_fill_valid, i_done, d_fill_valid, d_done, fill_data, fill_word,
           busy, mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
    input  i_fill_valid, i_done, d_fill_valid, d_done, fill_data, fill_word,
           busy, mem_en, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker (combinational).
//   req_i, req_d : requests from the I and D sides
//   last_grant   : owner of the most recent grant
//   grant_valid  : some side is requesting
//   grant_sel    : chosen side; on a tie, the side that was not granted last
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  grant_e last_grant,
  output logic   grant_valid,
  output grant_e grant_sel
);

  always_comb begin
    grant_valid = req_i | req_d;
    grant_sel   = GRANT_I;
    if (req_i && req_d) begin
      grant_sel = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (req_d) begin
      grant_sel = GRANT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one pipelined single-port memory between I-cache and D-cache
// miss handlers: 8-word block fills for either side, single-word D writes.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_arbiter_if.slave (cache handshakes, fill return, memory port)
// Fill returns, done pulses and memory commands are decoded from the state
// registers and mem_rvalid in the same cycle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  // Byte offset bits within a block: word index plus byte-in-word.
  localparam int unsigned OFF_W = WORD_IDX_W + 1;
  localparam int unsigned BLK_W = ADDR_W - OFF_W;

  state_e                state_q, state_d;
  // Extra MSB marks "all reads issued" so issuing stops without a flag.
  logic [OFF_W-1:0]      issue_cnt_q, issue_cnt_d;
  logic [WORD_IDX_W-1:0] ret_cnt_q, ret_cnt_d;
  grant_e                last_grant_q, last_grant_d;
  logic [BLK_W-1:0]      blk_q, blk_d;

  logic   grant_valid;
  grant_e grant_sel;
  logic   last_word;

  rr_pick2 u_pick (
    .req_i       (bus.i_req),
    .req_d       (bus.d_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  assign last_word = (ret_cnt_q == WORD_IDX_W'(BLOCK_WORDS - 1));

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      issue_cnt_q  <= '0;
      ret_cnt_q    <= '0;
      last_grant_q <= GRANT_I;
      blk_q        <= '0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      ret_cnt_q    <= ret_cnt_d;
      last_grant_q <= last_grant_d;
      blk_q        <= blk_d;
    end
  end

  // Next state: grant in IDLE, count issued reads and returned words.
  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    ret_cnt_d    = ret_cnt_q;
    last_grant_d = last_grant_q;
    blk_d        = blk_q;
    case (state_q)
      IDLE: begin
        issue_cnt_d = '0;
        ret_cnt_d   = '0;
        if (grant_valid) begin
          last_grant_d = grant_sel;
          if (grant_sel == GRANT_D) begin
            blk_d   = bus.d_addr[ADDR_W-1:OFF_W];
            state_d = bus.d_wr ? D_WRITE : D_FILL;
          end else begin
            blk_d   = bus.i_addr[ADDR_W-1:OFF_W];
            state_d = I_FILL;
          end
        end
      end
      I_FILL, D_FILL: begin
        if (!issue_cnt_q[WORD_IDX_W]) begin
          issue_cnt_d = issue_cnt_q + OFF_W'(1);
        end
        if (bus.mem_rvalid) begin
          ret_cnt_d = ret_cnt_q + WORD_IDX_W'(1);
          if (last_word) begin
            state_d = IDLE;
          end
        end
      end
      D_WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: memory command, fill return and done pulses for the owner only.
  always_comb begin
    bus.mem_en       = 1'b0;
    bus.mem_wr       = 1'b0;
    bus.mem_addr     = ADDR_W'(0);
    bus.mem_wdata    = DATA_W'(0);
    bus.fill_data    = DATA_W'(0);
    bus.fill_word    = WORD_IDX_W'(0);
    bus.i_fill_valid = 1'b0;
    bus.i_done       = 1'b0;
    bus.d_fill_valid = 1'b0;
    bus.d_done       = 1'b0;
    bus.busy         = (state_q != IDLE);
    case (state_q)
      I_FILL, D_FILL: begin
        bus.mem_en   = !issue_cnt_q[WORD_IDX_W];
        bus.mem_addr = {blk_q, issue_cnt_q[WORD_IDX_W-1:0], 1'b0};
        if (bus.mem_rvalid) begin
          bus.fill_data = bus.mem_rdata;
          bus.fill_word = ret_cnt_q;
          if (state_q == D_FILL) begin
            bus.d_fill_valid = 1'b1;
            bus.d_done       = last_word;
          end else begin
            bus.i_fill_valid = 1'b1;
            bus.i_done       = last_word;
          end
        end
      end
      D_WRITE: begin
        bus.mem_en    = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = {bus.d_addr[ADDR_W-1:1], 1'b0};
        bus.mem_wdata = bus.d_wdata;
        bus.d_done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-4 pipelined memory model and
// a scoreboard of expected read addresses and fill words.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct packed {
    logic        side;   // 1 = D
    logic [2:0]  word;
    logic [15:0] data;
  } fill_t;

  logic clk;
  logic rst;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // Memory: read accepted at a clock edge returns 4 cycles after issue.
  logic [3:0]  pv = 4'b0;
  logic [15:0] pd [4];
  always @(posedge clk) begin
    pv    <= {pv[2:0], bus.mem_en === 1'b1 && bus.mem_wr === 1'b0};
    pd[0] <= mem_fn(bus.mem_addr);
    pd[1] <= pd[0];
    pd[2] <= pd[1];
    pd[3] <= pd[2];
  end
  assign bus.mem_rvalid = pv[3];
  assign bus.mem_rdata  = pv[3] ? pd[3] : 16'h0000;

  fill_t       fq [$];
  logic [15:0] aq [$];

  int cyc = 0;
  int n_total = 0;
  int n_pass = 0;
  int n_fail = 0;
  int first_rd = -1;
  int first_fill = -1;
  int i_done_cyc = 0;
  int d_done_cyc = 0;
  int n_i_done = 0;
  int n_d_done = 0;
  int n_fill = 0;
  int n_rvalid = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_block(input logic side, input logic [15:0] addr);
    logic [15:0] a;
    for (int k = 0; k < 8; k++) begin
      a = {addr[15:4], 3'(k), 1'b0};
      aq.push_back(a);
      fq.push_back('{side: side, word: 3'(k), data: mem_fn(a)});
    end
  endtask

  // Advance one cycle and score everything the DUT produced in it.
  task automatic tick();
    fill_t       e;
    logic [15:0] a;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.mem_rvalid) n_rvalid++;
    if (bus.i_fill_valid || bus.d_fill_valid) begin
      n_fill++;
      if (first_fill < 0) first_fill = cyc;
      chk("fill_expected", 32'(fq.size() != 0), 32'd1);
      if (fq.size() != 0) begin
        e = fq.pop_front();
        chk("fill_side", 32'(bus.d_fill_valid), 32'(e.side));
        chk("fill_word", 32'(bus.fill_word), 32'(e.word));
        chk("fill_data", 32'(bus.fill_data), 32'(e.data));
      end
    end
    if (bus.mem_en && !bus.mem_wr) begin
      if (first_rd < 0) first_rd = cyc;
      chk("rd_expected", 32'(aq.size() != 0), 32'd1);
      if (aq.size() != 0) begin
        a = aq.pop_front();
        chk("rd_addr", 32'(bus.mem_addr), 32'(a));
      end
    end
    chk("one_owner", 32'((bus.i_fill_valid | bus.i_done) & (bus.d_fill_valid | bus.d_done)), 32'd0);
    if (bus.i_done) begin n_i_done++; i_done_cyc = cyc; end
    if (bus.d_done) begin n_d_done++; d_done_cyc = cyc; end
  endtask

  task automatic wait_done(input logic d_side, input int budget, input string tag);
    int n0;
    int k;
    n0 = d_side ? n_d_done : n_i_done;
    k  = 0;
    while (((d_side ? n_d_done : n_i_done) == n0) && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'((d_side ? n_d_done : n_i_done) - n0), 32'd1);
  endtask

  int t;
  int f0;
  int dn0;
  int rv0;

  initial begin
    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = 16'h0;
    bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = 16'h0; bus.d_wdata = 16'h0;
    repeat (5) tick();
    chk("rst_busy",   32'(bus.busy), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_ifv",    32'(bus.i_fill_valid), 32'd0);
    chk("rst_ddone",  32'(bus.d_done), 32'd0);
    chk("rst_fdata",  32'(bus.fill_data), 32'd0);
    rst = 1'b0;
    tick();

    // Isolated I fill.
    t = cyc; first_rd = -1; first_fill = -1;
    bus.i_req = 1'b1; bus.i_addr = 16'h1236;
    push_block(1'b0, 16'h1236);
    wait_done(1'b0, 30, "ifill_done");
    bus.i_req = 1'b0;
    chk("ifill_first_rd",   32'(first_rd), 32'(t + 1));
    chk("ifill_first_word", 32'(first_fill), 32'(t + 5));
    chk("ifill_done_cyc",   32'(i_done_cyc), 32'(t + 12));
    tick();
    chk("ifill_idle_after", 32'(bus.busy), 32'd0);

    // Single D write.
    bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0F03; bus.d_wdata = 16'hBEEF;
    tick();
    chk("wr_mem_en", 32'(bus.mem_en), 32'd1);
    chk("wr_mem_wr", 32'(bus.mem_wr), 32'd1);
    chk("wr_addr",   32'(bus.mem_addr), 32'h0F02);
    chk("wr_wdata",  32'(bus.mem_wdata), 32'hBEEF);
    chk("wr_done",   32'(bus.d_done), 32'd1);
    bus.d_req = 1'b0; bus.d_wr = 1'b0;
    tick();
    chk("wr_idle_after", 32'(bus.busy), 32'd0);
    chk("wr_wdata_idle", 32'(bus.mem_wdata), 32'd0);

    // Simultaneous pair right after reset: D wins, then I.
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 16'h2000;
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h3008;
    push_block(1'b1, 16'h3008);
    push_block(1'b0, 16'h2000);
    wait_done(1'b1, 30, "pair1_d_done");
    bus.d_req = 1'b0;
    first_rd = -1;
    wait_done(1'b0, 30, "pair1_i_done");
    bus.i_req = 1'b0;
    chk("pair1_order", 32'(d_done_cyc < i_done_cyc), 32'd1);
    chk("pair1_gap",   32'(first_rd), 32'(d_done_cyc + 2));
    tick();

    // D write leaves last_grant = D, so the next pair goes I first.
    bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0100; bus.d_wdata = 16'h1234;
    tick();
    chk("wr2_done", 32'(bus.d_done), 32'd1);
    bus.d_req = 1'b0; bus.d_wr = 1'b0;
    tick();
    bus.i_req = 1'b1; bus.i_addr = 16'h2224;
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h333E;
    push_block(1'b0, 16'h2224);
    push_block(1'b1, 16'h333E);
    wait_done(1'b0, 30, "pair2_i_done");
    bus.i_req = 1'b0;
    wait_done(1'b1, 30, "pair2_d_done");
    bus.d_req = 1'b0;
    chk("pair2_order", 32'(i_done_cyc < d_done_cyc), 32'd1);
    tick();

    // Address change and req drop mid D fill.
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h4A10;
    push_block(1'b1, 16'h4A10);
    f0 = n_fill;
    repeat (3) tick();
    bus.d_addr = 16'h7777; bus.d_req = 1'b0;
    wait_done(1'b1, 30, "addrchg_done");
    chk("addrchg_fills", 32'(n_fill - f0), 32'd8);
    tick();
    chk("addrchg_idle", 32'(bus.busy), 32'd0);

    // Reset during the third returned word.
    bus.i_req = 1'b1; bus.i_addr = 16'h5550;
    push_block(1'b0, 16'h5550);
    f0 = n_fill;
    for (int k = 0; k < 30 && (n_fill - f0) < 3; k++) tick();
    chk("rstfill_third", 32'(n_fill - f0), 32'd3);
    rst = 1'b1; bus.i_req = 1'b0;
    tick();
    chk("rstfill_busy",  32'(bus.busy), 32'd0);
    chk("rstfill_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rstfill_addr",  32'(bus.mem_addr), 32'd0);
    chk("rstfill_ifv",   32'(bus.i_fill_valid), 32'd0);
    chk("rstfill_idone", 32'(bus.i_done), 32'd0);
    chk("rstfill_fdata", 32'(bus.fill_data), 32'd0);
    rst = 1'b0;
    fq.delete(); aq.delete();
    f0 = n_fill; dn0 = n_i_done + n_d_done; rv0 = n_rvalid;
    repeat (8) tick();
    chk("stale_no_fill", 32'(n_fill - f0), 32'd0);
    chk("stale_no_done", 32'(n_i_done + n_d_done - dn0), 32'd0);
    chk("stale_rvalid_seen", 32'(n_rvalid - rv0 > 0), 32'd1);

    // Back-to-back I fills with i_req held.
    bus.i_req = 1'b1; bus.i_addr = 16'h6000;
    push_block(1'b0, 16'h6000);
    wait_done(1'b0, 30, "b2b_first_done");
    t = i_done_cyc;
    bus.i_addr = 16'h6010; first_rd = -1;
    push_block(1'b0, 16'h6010);
    wait_done(1'b0, 30, "b2b_second_done");
    bus.i_req = 1'b0;
    chk("b2b_gap", 32'(first_rd), 32'(t + 2));
    tick();
    chk("b2b_idle", 32'(bus.busy), 32'd0);

    chk("fill_queue_empty", 32'(fq.size()), 32'd0);
    chk("rd_queue_empty",   32'(aq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported, pipelined main memory between the I-cache and D-cache miss handlers.
- Sequences 8-word block fills for either requester and single-word D-side write-throughs.
- Grants the memory to one transaction at a time; requests arriving while busy are held.
- Alternates the grant when both caches request at once.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width.
- BLOCK_WORDS, 8, words per cache block; must be a power of 2 (16-byte blocks).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_req  in  1  I-cache fill request; held until i_done
- i_addr  in  ADDR_W  I-side miss address; low offset bits ignored
- i_fill_valid  out  1  fill_data is a word for the I-cache
- i_done  out  1  1-cycle pulse: I fill complete
- d_req  in  1  D-cache request; held until d_done
- d_wr  in  1  1 = single-word write, 0 = block fill
- d_addr  in  ADDR_W  D-side address
- d_wdata  in  DATA_W  write data
- d_fill_valid  out  1  fill_data is a word for the D-cache
- d_done  out  1  1-cycle pulse: D transaction complete
- fill_data  out  DATA_W  returned word, shared by both caches
- fill_word  out  log2(BLOCK_WORDS)  word index of fill_data within the block
- mem_en  out  1  memory command valid
- mem_wr  out  1  memory write
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_rvalid  in  1  mem_rdata valid; in-order, fixed latency, 1 per read
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, I_FILL, D_FILL, D_WRITE.
- Reset: state IDLE, counters 0, last_grant = I. All outputs 0.
- IDLE arbitration, sampled only in IDLE:
  - Only d_req: go to D_WRITE if d_wr, else D_FILL.
  - Only i_req: go to I_FILL.
  - Both: grant the side not equal to last_grant. last_grant updates on entry to any non-IDLE state.
- Fill issue:
  - issue_cnt runs 0..BLOCK_WORDS-1; one read per cycle starting the cycle after the grant.
  - mem_en=1, mem_wr=0, mem_addr = {latched_addr[15:4], issue_cnt, 1'b0}.
  - Address is latched at grant; later changes to i_addr/d_addr are ignored.
- Fill return:
  - ret_cnt counts mem_rvalid, but only in a FILL state.
  - Each rvalid drives fill_data = mem_rdata, fill_word = ret_cnt, and the owner's *_fill_valid, all combinationally in the same cycle.
  - On the BLOCK_WORDS-th rvalid, the owner's *_done pulses in that same cycle; next state is IDLE.
- Fill timing, memory latency 4, request seen in IDLE at cycle t:
  - Reads issued t+1..t+8.
  - Words returned t+5..t+12; done at t+12.
  - IDLE at t+13; the next grant can occur at t+13.
- D_WRITE: lasts one cycle.
  - mem_en=1, mem_wr=1, mem_addr = {d_addr[15:1],1'b0}, mem_wdata = d_wdata.
  - d_done pulses in that cycle; next state is IDLE.
  - Write-to-grant gap is 1 IDLE cycle.
- Outside D_WRITE, mem_wr=0 and mem_wdata=0.
- Requester deasserting req mid-transaction: ignored; the transaction completes and done still pulses.
- Waiting requester: keeps req high; nothing is dropped.
- mem_rvalid in IDLE or D_WRITE: ignored. This covers stale returns after reset.
- Reset mid-fill: IDLE next cycle, counters cleared, no done pulse.
- fill_valid and done never go to the non-owner. At most one of i_*/d_* outputs is active per cycle.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, I_FILL, D_FILL, D_WRITE);
  - the BLOCK_WORDS and WORD_IDX_W constants;
  - the grant encoding (GRANT_I=0, GRANT_D=1).
- Sub-module rr_pick2: 2-way round-robin picker, combinational; inputs req_i, req_d, last_grant; outputs grant_valid, grant_sel.

Test Plan:
- Isolated I fill: i_req=1, i_addr=0x1236 at t, memory latency 4.
  - mem_addr sequence 0x1230,0x1232,…,0x123E at t+1..t+8.
  - i_fill_valid with fill_word 0..7 at t+5..t+12; i_done at t+12; busy low at t+13.
- D write: d_req=1, d_wr=1, d_addr=0x0F03, d_wdata=0xBEEF.
  - Next cycle: mem_en=1, mem_wr=1, mem_addr=0x0F02, mem_wdata=0xBEEF, d_done=1.
  - Following cycle: IDLE.
- Simultaneous requests: i_req and d_req rise together after reset (last_grant=I).
  - D_FILL is served first, then I_FILL.
  - A second simultaneous pair is served I first.
- Address change mid-fill: change d_addr and drop d_req during D_FILL.
  - mem_addr stays on the latched block; all 8 d_fill_valid and d_done still occur.
- Reset mid-fill: assert rst during the 3rd returned word.
  - Next cycle IDLE, all outputs 0.
  - Later mem_rvalid pulses produce no fill_valid or done.
- Back-to-back fills: i_req held continuously across two fills.
  - Exactly one IDLE cycle between i_done and the next mem_en.
